// File: rtl/linear_proj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linear_proj_pkg
// Description : Shared constants and enumerations for the linear projection
//               sequencing controller (matrix A size, tiling, head count,
//               projection selector and scheduler state encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package linear_proj_pkg;

  localparam int NUM_A_ELEMENTS = 64;
  localparam int ADDR_WIDTH_A   = 6;
  localparam int TOTAL_INPUT_W  = 4;
  localparam int NUM_HEADS      = 4;

  typedef enum logic [1:0] {
    PROJ_Q = 2'd0,
    PROJ_K = 2'd1,
    PROJ_V = 2'd2
  } proj_sel_t;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/input_load_tracker.sv
`default_nettype none
// ============================================================================
// Module      : input_load_tracker
// Description : Snoops both write ports of the input-matrix BRAM and keeps a
//               per-word written bitmap. o_loaded is high once every word of
//               matrix A has been written at least once.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               i_track           - accumulate accepted writes into bitmap
//               i_restart         - replace bitmap with this cycle's writes
//                                   (only when a write is actually accepted)
//               i_ena/i_wea/i_addra, i_enb/i_web/i_addrb - snooped ports
//               o_wr_any          - an in-range write is present this cycle
//               o_loaded          - all bitmap bits set
// Revision    : 1.0 - initial release
// ============================================================================
module input_load_tracker #(
  parameter int NUM_A_ELEMENTS = 64,
  parameter int ADDR_WIDTH_A   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_track,
  input  logic                    i_restart,
  input  logic                    i_ena,
  input  logic                    i_wea,
  input  logic [ADDR_WIDTH_A-1:0] i_addra,
  input  logic                    i_enb,
  input  logic                    i_web,
  input  logic [ADDR_WIDTH_A-1:0] i_addrb,
  output logic                    o_wr_any,
  output logic                    o_loaded
);

  localparam logic [NUM_A_ELEMENTS-1:0] c_one = {{(NUM_A_ELEMENTS-1){1'b0}}, 1'b1};

  logic [NUM_A_ELEMENTS-1:0] r_bitmap;
  logic                      w_hit_a;
  logic                      w_hit_b;
  logic [NUM_A_ELEMENTS-1:0] w_set;

  assign w_hit_a = i_ena & i_wea & (int'(i_addra) < NUM_A_ELEMENTS);
  assign w_hit_b = i_enb & i_web & (int'(i_addrb) < NUM_A_ELEMENTS);

  // OR-ing the two one-hot masks makes a same-address dual write count once.
  assign w_set = (w_hit_a ? (c_one << i_addra) : '0) |
                 (w_hit_b ? (c_one << i_addrb) : '0);

  assign o_wr_any = w_hit_a | w_hit_b;
  assign o_loaded = &r_bitmap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitmap <= '0;
    end else if (i_restart && o_wr_any) begin
      r_bitmap <= w_set;
    end else if (i_track) begin
      r_bitmap <= r_bitmap | w_set;
    end
  end

endmodule
`default_nettype wire

// File: rtl/linear_proj_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : linear_proj_scheduler
// Description : Waits for matrix A to be fully written, then issues one core
//               start per (tile, projection, head) job, head innermost,
//               waits for each core completion and pulses out_valid. Raises
//               done after the final job; the next write restarts loading.
// Ports       : clk, rst_n                    - clock, sync active-low reset
//               in_mat_ena/wea/wr_addra       - snooped BRAM port A
//               in_mat_enb/web/wr_addrb       - snooped BRAM port B
//               core_start / core_done        - projection core handshake
//               proj_sel, head_sel, tile_idx  - current job selectors
//               busy, out_valid, done         - status decoded from state
//               err_overwrite                 - sticky write-while-busy flag
// Revision    : 1.0 - initial release
// ============================================================================
module linear_proj_scheduler #(
  parameter int NUM_A_ELEMENTS = linear_proj_pkg::NUM_A_ELEMENTS,
  parameter int ADDR_WIDTH_A   = linear_proj_pkg::ADDR_WIDTH_A,
  parameter int TOTAL_INPUT_W  = linear_proj_pkg::TOTAL_INPUT_W,
  parameter int NUM_HEADS      = linear_proj_pkg::NUM_HEADS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_mat_ena,
  input  logic                             in_mat_wea,
  input  logic [ADDR_WIDTH_A-1:0]          in_mat_wr_addra,
  input  logic                             in_mat_enb,
  input  logic                             in_mat_web,
  input  logic [ADDR_WIDTH_A-1:0]          in_mat_wr_addrb,
  output logic                             core_start,
  input  logic                             core_done,
  output logic [1:0]                       proj_sel,
  output logic [$clog2(NUM_HEADS)-1:0]     head_sel,
  output logic [$clog2(TOTAL_INPUT_W)-1:0] tile_idx,
  output logic                             busy,
  output logic                             out_valid,
  output logic                             done,
  output logic                             err_overwrite
);

  import linear_proj_pkg::*;

  localparam int HW = $clog2(NUM_HEADS);
  localparam int TW = $clog2(TOTAL_INPUT_W);
  localparam logic [HW-1:0] c_head_last = HW'(NUM_HEADS - 1);
  localparam logic [TW-1:0] c_tile_last = TW'(TOTAL_INPUT_W - 1);

  sched_state_t  r_state;
  sched_state_t  w_next;
  proj_sel_t     r_proj;
  logic [HW-1:0] r_head;
  logic [TW-1:0] r_tile;
  logic          r_err;
  logic          w_wr_any;
  logic          w_loaded;
  logic          w_last;
  logic          w_restart;

  input_load_tracker #(
    .NUM_A_ELEMENTS (NUM_A_ELEMENTS),
    .ADDR_WIDTH_A   (ADDR_WIDTH_A)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_track   (r_state == S_LOAD),
    .i_restart (r_state == S_DONE),
    .i_ena     (in_mat_ena),
    .i_wea     (in_mat_wea),
    .i_addra   (in_mat_wr_addra),
    .i_enb     (in_mat_enb),
    .i_web     (in_mat_web),
    .i_addrb   (in_mat_wr_addrb),
    .o_wr_any  (w_wr_any),
    .o_loaded  (w_loaded)
  );

  assign w_last    = (r_tile == c_tile_last) && (r_proj == PROJ_V) && (r_head == c_head_last);
  assign w_restart = (r_state == S_DONE) && w_wr_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_loaded) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        busy       = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_done) w_next = S_RESULT;
      end
      S_RESULT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        w_next    = w_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_wr_any) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Selectors only move on RESULT exit so they stay stable from start to
  // out_valid; after the last job they hold until a restart write.
  always_ff @(posedge clk) begin
    if (!rst_n || w_restart) begin
      r_proj <= PROJ_Q;
      r_head <= '0;
      r_tile <= '0;
    end else if (r_state == S_RESULT && !w_last) begin
      if (r_head == c_head_last) begin
        r_head <= '0;
        case (r_proj)
          PROJ_Q:  r_proj <= PROJ_K;
          PROJ_K:  r_proj <= PROJ_V;
          default: begin
            r_proj <= PROJ_Q;
            r_tile <= r_tile + 1'b1;
          end
        endcase
      end else begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (busy && w_wr_any) begin
      r_err <= 1'b1;
    end
  end

  assign proj_sel      = r_proj;
  assign head_sel      = r_head;
  assign tile_idx      = r_tile;
  assign err_overwrite = r_err;

endmodule
`default_nettype wire

// File: tb/tb_linear_proj_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_proj_scheduler
// Description : Scoreboard bench for linear_proj_scheduler. Expected jobs are
//               queued from nested loops when a run is launched; a monitor
//               pops and compares on every out_valid. A core model answers
//               core_start after a fixed/random delay or holds core_done high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_proj_scheduler;
  import linear_proj_pkg::*;

  localparam int N    = NUM_A_ELEMENTS;
  localparam int AW   = ADDR_WIDTH_A;
  localparam int T    = TOTAL_INPUT_W;
  localparam int H    = NUM_HEADS;
  localparam int JOBS = T * 3 * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic core_done = 1'b0;
  logic core_start, busy, out_valid, done, err_overwrite;
  logic [1:0] proj_sel;
  logic [$clog2(H)-1:0] head_sel;
  logic [$clog2(T)-1:0] tile_idx;

  always #5 clk = ~clk;

  linear_proj_scheduler #(
    .NUM_A_ELEMENTS (N),
    .ADDR_WIDTH_A   (AW),
    .TOTAL_INPUT_W  (T),
    .NUM_HEADS      (H)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_mat_ena      (ena),
    .in_mat_wea      (wea),
    .in_mat_wr_addra (addra),
    .in_mat_enb      (enb),
    .in_mat_web      (web),
    .in_mat_wr_addrb (addrb),
    .core_start      (core_start),
    .core_done       (core_done),
    .proj_sel        (proj_sel),
    .head_sel        (head_sel),
    .tile_idx        (tile_idx),
    .busy            (busy),
    .out_valid       (out_valid),
    .done            (done),
    .err_overwrite   (err_overwrite)
  );

  typedef struct { int t; int p; int h; } job_t;
  job_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_start = 0;
  int run_start_cnt = 0;
  int n_valid = 0;
  int st_sel = 0;
  bit hold_done = 1'b0;
  bit rand_dly = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sel_code();
    return int'(tile_idx) * 100 + int'(proj_sel) * 10 + int'(head_sel);
  endfunction

  // Reference job order: tile outermost, then Q/K/V, head innermost.
  task automatic push_run();
    for (int t = 0; t < T; t++)
      for (int p = 0; p < 3; p++)
        for (int h = 0; h < H; h++)
          exp_q.push_back('{t, p, h});
  endtask

  always @(posedge clk) cyc++;

  // Monitor: selector stability, period in hold mode, scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) begin
        if (hold_done && run_start_cnt > 0) check("job_period", cyc - last_start, 3);
        last_start = cyc;
        st_sel = sel_code();
        run_start_cnt++;
      end
      if (out_valid) begin
        job_t j;
        check("sel_stable", sel_code(), st_sel);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          j = exp_q.pop_front();
          check("job_order", sel_code(), j.t * 100 + j.p * 10 + j.h);
        end
        n_valid++;
      end
    end
  end

  // Core model: completion pulse some cycles after start, or held high.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_done) begin
        core_done = 1'b1;
      end else if (core_start) begin
        int dly;
        core_done = 1'b0;
        dly = rand_dly ? int'($urandom_range(1, 6)) : 5;
        repeat (dly) begin
          @(posedge clk);
          #1;
        end
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end else begin
        core_done = 1'b0;
      end
    end
  end

  // One write cycle; called at posedge+1 and returns at next posedge+1.
  task automatic drive(input logic ea, input logic wa, input int aa,
                       input logic eb, input logic wb, input int ab);
    ena = ea; wea = wa; addra = AW'(aa);
    enb = eb; web = wb; addrb = AW'(ab);
    @(posedge clk);
    #1;
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    check("start_lat_c1", core_start, 0);
    @(posedge clk);
    @(negedge clk);
    check("start_lat_c2", core_start, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_even_odd();
    for (int i = 0; i < N / 2; i++) drive(1, 1, 2 * i, 1, 1, 2 * i + 1);
  endtask

  // Shuffled load of every address except 'skip', one or two per cycle.
  task automatic load_random(input int skip);
    int q[$];
    int k;
    int tmp;
    for (int a = 0; a < N; a++) if (a != skip) q.push_back(a);
    for (int i = q.size() - 1; i > 0; i--) begin
      k = int'($urandom_range(0, i));
      tmp = q[i]; q[i] = q[k]; q[k] = tmp;
    end
    k = 0;
    while (k < q.size()) begin
      if (k + 1 < q.size() && $urandom_range(0, 1) == 1) begin
        drive(1, 1, q[k], 1, 1, q[k + 1]);
        k += 2;
      end else if ($urandom_range(0, 1) == 1) begin
        drive(1, 1, q[k], 0, 0, 0);
        k++;
      end else begin
        drive(0, 0, 0, 1, 1, q[k]);
        k++;
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_reached", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (run_start_cnt >= n) break;
    end
    check("starts_reached", run_start_cnt >= n, 1);
  endtask

  task automatic start_run();
    run_start_cnt = 0;
    n_valid = 0;
    push_run();
  endtask

  task automatic end_of_run();
    @(negedge clk);
    check("valid_count", n_valid, JOBS);
    check("queue_empty", exp_q.size(), 0);
    check("done_level", done, 1);
    check("busy_in_done", busy, 0);
    check("last_sel", sel_code(), (T - 1) * 100 + 2 * 10 + (H - 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outs", {core_start, out_valid, done, busy, err_overwrite,
                         proj_sel, head_sel, tile_idx}, 0);
    @(posedge clk);
    #1;

    // Run 1: even/odd paired load, fixed 5-cycle core.
    start_run();
    load_even_odd();
    check_latency();
    wait_done();
    end_of_run();
    check("err_clean", err_overwrite, 0);

    // Run 2: single write in DONE restarts; random load, random core delay,
    // plus a write while busy at job 10.
    drive(0, 0, 0, 1, 1, 5);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("busy_after_restart", busy, 0);
    @(posedge clk);
    #1;
    rand_dly = 1'b1;
    start_run();
    load_random(5);
    check_latency();
    wait_starts(11);
    drive(1, 1, 7, 0, 0, 0);
    @(negedge clk);
    check("err_set", err_overwrite, 1);
    @(posedge clk);
    #1;
    wait_done();
    end_of_run();
    check("err_sticky_run2", err_overwrite, 1);
    rand_dly = 1'b0;

    // Run 3: 63 distinct addresses (duplicate last pair) must not start.
    run_start_cnt = 0;
    for (int i = 0; i < 31; i++) drive(1, 1, 2 * i, 1, 1, 2 * i + 1);
    drive(1, 1, 62, 1, 1, 62);
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("dup_no_start", run_start_cnt, 0);
    check("dup_not_busy", busy, 0);
    check("dup_not_done", done, 0);
    @(posedge clk);
    #1;
    drive(1, 0, 63, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("en_no_we_ignored", run_start_cnt, 0);
    hold_done = 1'b1;
    start_run();
    drive(1, 1, 63, 0, 0, 0);
    check_latency();
    wait_done();
    end_of_run();
    hold_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Run 4: reset during job 20, then full reload from the beginning.
    start_run();
    drive(1, 1, 0, 0, 0, 0);
    load_random(0);
    check_latency();
    wait_starts(21);
    check("err_before_rst", err_overwrite, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midjob_reset_outs", {core_start, out_valid, done, busy, err_overwrite,
                                proj_sel, head_sel, tile_idx}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    check("no_start_after_rst", run_start_cnt, 21);
    start_run();
    load_even_odd();
    check_latency();
    wait_done();
    end_of_run();
    check("err_after_rerun", err_overwrite, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/linear_proj_scheduler.md
# linear_proj_scheduler

Sequencing controller for the multi-head linear projection datapath. It snoops the dual-port input-matrix BRAM writes to decide when matrix A is fully loaded. It then issues one start per (input tile, projection Q/K/V, head) job to the shared projection core, waits for each core completion, and flags results as valid. When the whole Q/K/V set is finished it raises `done`. It sits between the input BRAM writer and the projection core inside the linear projection top level.

## Interface
Parameters:
- `NUM_A_ELEMENTS`, 64: number of BRAM words holding matrix A.
- `ADDR_WIDTH_A`, 6: BRAM address width.
- `TOTAL_INPUT_W`, 4: number of input column tiles.
- `NUM_HEADS`, 4: heads per projection.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_mat_ena`, `in_mat_wea`  in  1 each  port A enable / write enable (snooped).
- `in_mat_wr_addra`  in  ADDR_WIDTH_A  port A write address.
- `in_mat_enb`, `in_mat_web`  in  1 each  port B enable / write enable (snooped).
- `in_mat_wr_addrb`  in  ADDR_WIDTH_A  port B write address.
- `core_start`  out  1  one-cycle start pulse to the projection core.
- `core_done`  in  1  core job-complete pulse.
- `proj_sel`  out  2  0=Q, 1=K, 2=V (3 never driven).
- `head_sel`  out  $clog2(NUM_HEADS)  current head.
- `tile_idx`  out  $clog2(TOTAL_INPUT_W)  current input tile.
- `busy`  out  1  high in ISSUE/WAIT/RESULT.
- `out_valid`  out  1  one-cycle pulse; the core output for the current selectors is valid.
- `done`  out  1  level; all jobs complete.
- `err_overwrite`  out  1  sticky; a write arrived while busy.

## Operation
- A write is a port cycle with en&we=1 and address < NUM_A_ELEMENTS. Writes with other addresses are ignored.
- A NUM_A_ELEMENTS-bit written-bitmap records accepted writes. Both ports may write in the same cycle; if both hit the same address, that address counts once. `loaded` = all bitmap bits set.
- FSM states:
  - LOAD (reset state): track writes. When `loaded`=1, go to ISSUE.
  - ISSUE: `core_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until `core_done`=1, then go to RESULT. `core_done` is ignored in every other state.
  - RESULT: `out_valid`=1 for one cycle with the selectors still showing the finished job. Then advance the counters. If the job just finished was the last, go to DONE; otherwise go to ISSUE.
- Job order is nested, with head innermost: tile 0..TOTAL_INPUT_W-1, then proj Q,K,V, then head 0..NUM_HEADS-1. Total jobs = TOTAL_INPUT_W×3×NUM_HEADS (48 at defaults).
- DONE: `done`=1, selectors hold the last job. The first write seen in DONE does all of the following, and the FSM returns to LOAD:
  - clears `done`;
  - clears the bitmap, except the bits for that write, which are set;
  - resets the counters to 0.
- Writes during ISSUE/WAIT/RESULT do not touch the bitmap and set `err_overwrite`. `err_overwrite` clears only on reset.
- Reset (including mid-job) does all of the following: state goes to LOAD; bitmap, counters, `core_start`, `out_valid`, `done`, `busy`, `err_overwrite` all go to 0; `proj_sel`, `head_sel`, `tile_idx` go to 0.

## Timing
- Every output is registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Load-to-start latency: the final completing write is presented in cycle c; `core_start` is high in cycle c+2.
- `core_done` sampled high in WAIT in cycle d gives `out_valid` high in cycle d+1 and `core_start` for the next job in cycle d+2.
- Minimum job period is 3 cycles (ISSUE, WAIT with `core_done` already high, RESULT).
- `done` rises in the cycle after the final RESULT.
- Selectors change only on exit from RESULT and are stable from `core_start` through `out_valid`.

## Structure
- `linear_proj_pkg` holds:
  - `NUM_A_ELEMENTS`, `TOTAL_INPUT_W`, `NUM_HEADS` constants;
  - `proj_sel_t` enum {PROJ_Q, PROJ_K, PROJ_V};
  - `sched_state_t` enum {S_LOAD, S_ISSUE, S_WAIT, S_RESULT, S_DONE}.
- Sub-module `input_load_tracker` contains the bitmap, the dual-port write decode, the clear-with-set behaviour and the `loaded` output. The FSM and counters stay in the top.

## Test plan
- Even/odd paired load of 64 words (port A even, port B odd, 32 cycles), with a core model that returns `core_done` 5 cycles after `core_start` -> `core_start` 2 cycles after the last write; 48 `out_valid` pulses in the nested order; `done`=1 after the 48th.
- Load with only 63 distinct addresses, the last pair duplicated on both ports -> stays in LOAD, no `core_start`; writing address 63 then starts the sequence.
- `core_done` held high continuously -> 3-cycle job period; `out_valid` count=48; selectors stable across each start..valid window.
- Port A write at job 10 while WAIT -> `err_overwrite`=1 and remains set; bitmap unchanged; job sequence unaffected.
- `rst_n`=0 for 1 cycle during job 20 -> next cycle all outputs 0 and state LOAD; a full reload re-runs from tile 0/Q/head 0.
- In DONE, a single write to address 5 -> `done`=0 next cycle, state LOAD; completing the remaining 63 addresses triggers a second full 48-job run.
